// File: rtl/ccff_pkg.sv
// Shared types and sizing helpers for the ccff chain loader.
// Word-count helpers are constant functions used to size the loader's counters.
package ccff_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROBE,
        ST_LOAD,
        ST_DONE,
        ST_ERR
    } state_e;

    function automatic int word_count(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // The final word carries only the bits still needed to fill the chain.
    function automatic int last_word_bits(input int chain_len, input int word_w);
        return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// One-word holding buffer that hands out bits MSB-first with zero-bubble refill.
// The final word stops early so its unused low bits are discarded.
module ccff_word_serializer #(
    parameter int WORD_W    = 8,
    parameter int LAST_BITS = WORD_W
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              i_enable,
    input  logic              i_final,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_valid,
    input  logic              i_advance,
    output logic              o_ready,
    output logic              o_bit,
    output logic              o_bit_valid,
    output logic              o_last
);

    localparam int PTR_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [PTR_W-1:0] TOP_IDX   = PTR_W'(WORD_W - 1);
    localparam logic [PTR_W-1:0] FINAL_IDX = PTR_W'(WORD_W - LAST_BITS);

    logic [WORD_W-1:0] r_buf;
    logic [PTR_W-1:0]  r_ptr;
    logic              r_full;
    logic              r_final;

    logic [PTR_W-1:0]  w_stop_idx;
    logic              w_accept;

    assign w_stop_idx  = r_final ? FINAL_IDX : '0;
    assign o_last      = r_full && (r_ptr == w_stop_idx);
    assign o_ready     = i_enable && (!r_full || (o_last && i_advance));
    assign w_accept    = o_ready && i_valid;
    assign o_bit       = r_buf[r_ptr];
    assign o_bit_valid = r_full;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            // NOTE: the data buffer is reset too; it is one word, so this costs nothing and keeps head clean.
            r_buf   <= '0;
            r_ptr   <= TOP_IDX;
            r_full  <= 1'b0;
            r_final <= 1'b0;
        end else if (w_accept) begin
            r_buf   <= i_data;
            r_ptr   <= TOP_IDX;
            r_full  <= 1'b1;
            r_final <= i_final;
        end else if (i_advance && r_full) begin
            if (o_last) begin
                r_full <= 1'b0;
            end else begin
                r_ptr <= r_ptr - PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Drives the ccff chain: optional marker probe of chain length, then a gated
// MSB-first bitstream load; releases pad isolation only after a clean load.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int PROBE_EN  = 1,
    parameter int CNT_W     = $clog2(2 * CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              isol_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  shift_count
);

    localparam int WORDS     = word_count(CHAIN_LEN, WORD_W);
    localparam int LAST_BITS = last_word_bits(CHAIN_LEN, WORD_W);
    localparam int WCNT_W    = $clog2(WORDS + 1);

    localparam logic [CNT_W-1:0]  LEN_CNT   = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0]  LEN_M1    = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(2 * CHAIN_LEN);
    localparam logic [WCNT_W-1:0] WORDS_CNT = WCNT_W'(WORDS);
    localparam logic [WCNT_W-1:0] FINAL_CNT = WCNT_W'(WORDS - 1);

    state_e            r_state;
    state_e            w_next;
    logic [CNT_W-1:0]  r_shift_count;
    logic [WCNT_W-1:0] r_words;
    logic              r_done;

    logic              w_shift_en;
    logic              w_head;
    logic              w_cnt_clr;
    logic              w_cnt_inc;
    logic              w_enter_load;
    logic [WCNT_W-1:0] w_words_seen;
    logic              w_fill_en;
    logic              w_final;
    logic              w_advance;
    logic              w_ready;
    logic              w_bit;
    logic              w_bit_valid;
    logic              w_last;

    // Words may already be taken in the cycle that enters LOAD, so the first LOAD cycle shifts.
    assign w_words_seen = (r_state == ST_LOAD) ? r_words : '0;
    assign w_fill_en    = ((r_state == ST_LOAD) || w_enter_load) && (w_words_seen < WORDS_CNT);
    assign w_final      = (w_words_seen == FINAL_CNT);
    assign w_advance    = (r_state == ST_LOAD) && w_bit_valid;

    ccff_word_serializer #(
        .WORD_W   (WORD_W),
        .LAST_BITS(LAST_BITS)
    ) u_serializer (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .i_enable   (w_fill_en),
        .i_final    (w_final),
        .i_data     (cfg_data),
        .i_valid    (cfg_valid),
        .i_advance  (w_advance),
        .o_ready    (w_ready),
        .o_bit      (w_bit),
        .o_bit_valid(w_bit_valid),
        .o_last     (w_last)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_next       = r_state;
        w_shift_en   = 1'b0;
        w_head       = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_enter_load = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    w_cnt_clr = 1'b1;
                    if (PROBE_EN != 0) begin
                        w_next = ST_PROBE;
                    end else begin
                        w_next       = ST_LOAD;
                        w_enter_load = 1'b1;
                    end
                end
            end
            ST_PROBE: begin
                if (ccff_tail) begin
                    if (r_shift_count == LEN_CNT) begin
                        w_next       = ST_LOAD;
                        w_cnt_clr    = 1'b1;
                        w_enter_load = 1'b1;
                    end else begin
                        w_next = ST_ERR;
                    end
                end else if (r_shift_count >= MAX_CNT) begin
                    w_next = ST_ERR;
                end else begin
                    w_shift_en = 1'b1;
                    w_head     = (r_shift_count == '0);
                    w_cnt_inc  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (w_bit_valid) begin
                    w_shift_en = 1'b1;
                    w_head     = w_bit;
                    w_cnt_inc  = 1'b1;
                    if ((r_shift_count == LEN_M1) && w_last) begin
                        w_next = ST_DONE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            r_state       <= ST_IDLE;
            r_shift_count <= '0;
            r_words       <= '0;
            r_done        <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == ST_DONE) && (r_state != ST_DONE);
            if (w_cnt_clr) begin
                r_shift_count <= '0;
            end else if (w_cnt_inc) begin
                r_shift_count <= r_shift_count + CNT_W'(1);
            end
            if (w_ready && cfg_valid) begin
                r_words <= w_words_seen + WCNT_W'(1);
            end else if (r_state != ST_LOAD) begin
                r_words <= '0;
            end
        end
    end

    assign cfg_ready     = w_ready;
    assign ccff_head     = w_head;
    assign ccff_shift_en = w_shift_en;
    assign isol_n        = (r_state == ST_DONE);
    assign busy          = (r_state == ST_PROBE) || (r_state == ST_LOAD);
    assign done          = r_done;
    assign error         = (r_state == ST_ERR);
    assign shift_count   = r_shift_count;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: behavioural shift-register chains, a word source,
// table-driven and randomized loads, plus probe-failure, stall, no-probe and reset sequences.
module tb_ccff_chain_loader;

    logic prog_clk = 1'b0;
    logic prog_reset;
    always #5 prog_clk = ~prog_clk;

    // DUT A: 20-stage chain, 8-bit words, probe enabled
    logic       start_a, cfg_valid_a, cfg_ready_a, head_a, shift_en_a, tail_a;
    logic       isol_n_a, busy_a, done_a, error_a;
    logic [7:0] cfg_data_a;
    logic [5:0] shift_count_a;

    // DUT B: 16-stage chain, 8-bit words, probe disabled
    logic       start_b, cfg_valid_b, cfg_ready_b, head_b, shift_en_b, tail_b;
    logic       isol_n_b, busy_b, done_b, error_b;
    logic [7:0] cfg_data_b;
    logic [5:0] shift_count_b;

    ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8), .PROBE_EN(1)) u_dut_a (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_a),
        .cfg_data(cfg_data_a), .cfg_valid(cfg_valid_a), .cfg_ready(cfg_ready_a),
        .ccff_head(head_a), .ccff_shift_en(shift_en_a), .ccff_tail(tail_a),
        .isol_n(isol_n_a), .busy(busy_a), .done(done_a), .error(error_a),
        .shift_count(shift_count_a)
    );

    ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8), .PROBE_EN(0)) u_dut_b (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_b),
        .cfg_data(cfg_data_b), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
        .ccff_head(head_b), .ccff_shift_en(shift_en_b), .ccff_tail(tail_b),
        .isol_n(isol_n_b), .busy(busy_b), .done(done_b), .error(error_b),
        .shift_count(shift_count_b)
    );

    // Physical chains: stage 0 takes head, the far stage drives tail.
    logic [39:0] chain_a = '0;
    logic [15:0] chain_b = '0;
    int          len_a = 20;
    bit          broken_a = 1'b0;
    bit          clr_a = 1'b0;
    bit          clr_b = 1'b0;

    always_comb tail_a = broken_a ? 1'b0 : chain_a[6'(len_a - 1)];
    always_comb tail_b = chain_b[15];

    always @(posedge prog_clk) begin
        if (clr_a) chain_a <= '0;
        else if (shift_en_a) chain_a <= {chain_a[38:0], head_a};
        if (clr_b) chain_b <= '0;
        else if (shift_en_b) chain_b <= {chain_b[14:0], head_b};
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Word sources and observed activity
    logic [7:0] a_words[$];
    logic [7:0] b_words[$];
    int a_widx, a_mode, a_hs, a_probe_sh, a_load_sh, a_load_cyc, a_stall, a_done, a_ready_seen, a_post_sh;
    int b_widx, b_hs, b_sh, b_done, b_hs_tick, b_first_shift;
    int tick_no = 0;

    task automatic clear_stats();
        a_widx = 0; a_hs = 0; a_probe_sh = 0; a_load_sh = 0; a_load_cyc = 0;
        a_stall = 0; a_done = 0; a_ready_seen = 0; a_post_sh = 0;
        b_widx = 0; b_hs = 0; b_sh = 0; b_done = 0; b_hs_tick = -1; b_first_shift = -1;
    endtask

    // One clock cycle: drive sources after the falling edge, observe, then cross the rising edge.
    task automatic tick();
        bit v;
        v = (a_widx < a_words.size());
        if (a_mode == 1 && a_load_cyc >= 7 && a_load_cyc <= 11) v = 1'b0;
        if (a_mode == 2 && $urandom_range(0, 2) == 0) v = 1'b0;
        cfg_valid_a = v;
        cfg_data_a  = v ? a_words[a_widx] : 8'($urandom);
        cfg_valid_b = (b_widx < b_words.size());
        cfg_data_b  = cfg_valid_b ? b_words[b_widx] : 8'h5A;
        #1;
        if (busy_a && a_hs > 0) begin
            a_load_cyc++;
            if (!shift_en_a) a_stall++;
        end
        if (shift_en_a) begin
            if (a_hs == 0) a_probe_sh++;
            else a_load_sh++;
        end
        if (cfg_ready_a) a_ready_seen++;
        if (done_a) a_done++;
        if (cfg_ready_a && cfg_valid_a) begin
            a_hs++;
            a_widx++;
        end
        if (cfg_ready_b && cfg_valid_b) begin
            b_hs++;
            b_widx++;
            if (b_hs == 1) b_hs_tick = tick_no;
        end
        if (shift_en_b) begin
            b_sh++;
            if (b_sh == 1) b_first_shift = tick_no;
        end
        if (done_b) b_done++;
        tick_no++;
        @(posedge prog_clk);
        @(negedge prog_clk);
    endtask

    task automatic clear_chains();
        clr_a = 1'b1; clr_b = 1'b1;
        tick();
        clr_a = 1'b0; clr_b = 1'b0;
        clear_stats();
    endtask

    task automatic wait_idle_a(input string name);
        bit timed_out;
        int sh0;
        timed_out = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (!busy_a) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        check({name, "_timeout"}, 32'(timed_out), 32'd0);
        sh0 = a_probe_sh + a_load_sh;
        repeat (3) tick();
        a_post_sh = a_probe_sh + a_load_sh - sh0;
    endtask

    task automatic run_a(input string name);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_idle_a(name);
    endtask

    typedef struct {
        logic [7:0]  w0, w1, w2;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [23:0] stream;
        logic [7:0]  rw[3];
        int t0;

        prog_reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        cfg_valid_a = 1'b0; cfg_valid_b = 1'b0;
        cfg_data_a = '0; cfg_data_b = '0;
        a_mode = 0;
        clear_stats();

        // Expected chain contents: first shifted bit lands at the far end (bit 19).
        tbl[0] = '{8'hA5, 8'h3C, 8'hF0, 20'hA53CF};
        tbl[1] = '{8'hFF, 8'h00, 8'h00, 20'hFF000};
        tbl[2] = '{8'h00, 8'h00, 8'hFF, 20'h0000F};
        tbl[3] = '{8'h12, 8'h34, 8'h56, 20'h12345};
        tbl[4] = '{8'hC3, 8'h81, 8'h7E, 20'hC3817};
        tbl[5] = '{8'h80, 8'h00, 8'h01, 20'h80000};
        tbl[6] = '{8'h00, 8'h00, 8'h0F, 20'h00000};

        #12;
        check("reset_outputs_a", {19'd0, cfg_ready_a, head_a, shift_en_a, isol_n_a, busy_a, done_a, error_a, shift_count_a}, 32'd0);
        check("reset_outputs_b", {19'd0, cfg_ready_b, head_b, shift_en_b, isol_n_b, busy_b, done_b, error_b, shift_count_b}, 32'd0);
        @(negedge prog_clk);
        prog_reset = 1'b0;

        // Table-driven full probe + load runs on a clean 20-stage chain.
        for (int i = 0; i < 7; i++) begin
            clear_chains();
            a_words = {tbl[i].w0, tbl[i].w1, tbl[i].w2};
            run_a($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_contents", i), 32'(chain_a[19:0]), 32'(tbl[i].exp));
            check($sformatf("tbl%0d_probe_shifts", i), 32'(a_probe_sh), 32'd20);
            check($sformatf("tbl%0d_load_cycles", i), 32'(a_load_cyc), 32'd20);
            check($sformatf("tbl%0d_handshakes", i), 32'(a_hs), 32'd3);
            check($sformatf("tbl%0d_done_pulses", i), 32'(a_done), 32'd1);
            check($sformatf("tbl%0d_isol_err_cnt", i), {24'd0, isol_n_a, error_a, shift_count_a}, {24'd0, 1'b1, 1'b0, 6'd20});
        end

        // Chain one stage short: marker arrives early.
        len_a = 19;
        clear_chains();
        a_words = {8'hA5, 8'h3C, 8'hF0};
        run_a("short");
        check("short_error_isol", {30'd0, error_a, isol_n_a}, {30'd0, 1'b1, 1'b0});
        check("short_probe_shifts", 32'(a_probe_sh), 32'd19);
        check("short_never_ready", 32'(a_ready_seen), 32'd0);
        check("short_no_done", 32'(a_done), 32'd0);
        check("short_idle_after", 32'(a_post_sh), 32'd0);

        // A fresh start clears the sticky error and the counter.
        clear_stats();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("restart_clears_error", {25'd0, error_a, shift_count_a}, 32'd0);
        wait_idle_a("restart");
        check("restart_error_again", 32'(error_a), 32'd1);

        // Open chain: tail never rises.
        len_a = 20;
        broken_a = 1'b1;
        clear_chains();
        run_a("open");
        check("open_probe_shifts", 32'(a_probe_sh), 32'd40);
        check("open_error_cnt", {25'd0, error_a, shift_count_a}, {25'd0, 1'b1, 6'd40});
        check("open_idle_after", 32'(a_post_sh), 32'd0);
        check("open_never_ready", 32'(a_ready_seen), 32'd0);
        broken_a = 1'b0;

        // Source stalls for 5 cycles right at the first refill point.
        clear_chains();
        a_mode = 1;
        a_words = {8'hA5, 8'h3C, 8'hF0};
        run_a("stall");
        check("stall_contents", 32'(chain_a[19:0]), 32'hA53CF);
        check("stall_load_cycles", 32'(a_load_cyc), 32'd25);
        check("stall_idle_cycles", 32'(a_stall), 32'd5);
        check("stall_done_pulses", 32'(a_done), 32'd1);

        // Random words and random valid gaps against the bitstream model.
        a_mode = 2;
        for (int k = 0; k < 6; k++) begin
            clear_chains();
            for (int j = 0; j < 3; j++) rw[j] = 8'($urandom);
            a_words = {rw[0], rw[1], rw[2]};
            stream = {rw[0], rw[1], rw[2]};
            run_a($sformatf("rnd%0d", k));
            check($sformatf("rnd%0d_contents", k), 32'(chain_a[19:0]), 32'(stream[23:4]));
            check($sformatf("rnd%0d_load_shifts", k), 32'(a_load_sh), 32'd20);
            check($sformatf("rnd%0d_done", k), {30'd0, isol_n_a, 1'b0} | 32'(a_done), 32'd3);
        end
        a_mode = 0;

        // No-probe instance: LOAD follows start directly.
        clear_chains();
        b_words = {8'hFF, 8'h00};
        t0 = tick_no;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int c = 0; c < 100 && busy_b; c++) tick();
        check("noprobe_timeout", 32'(busy_b), 32'd0);
        repeat (3) tick();
        check("noprobe_first_hs_at_start", 32'(b_hs_tick), 32'(t0));
        check("noprobe_first_shift", 32'(b_first_shift), 32'(t0 + 1));
        check("noprobe_handshakes", 32'(b_hs), 32'd2);
        check("noprobe_shifts", 32'(b_sh), 32'd16);
        check("noprobe_done", 32'(b_done), 32'd1);
        check("noprobe_contents", 32'(chain_b), 32'h0000FF00);
        check("noprobe_isol", 32'(isol_n_b), 32'd1);

        // Reset in the middle of a load, then a full rerun on the same chain.
        clear_chains();
        a_words = {8'h00, 8'h00, 8'h00};
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int c = 0; c < 200 && a_load_sh < 7; c++) tick();
        check("midload_reached_7", 32'(a_load_sh), 32'd7);
        #2;
        prog_reset = 1'b1;
        #1;
        check("midload_reset_outputs", {19'd0, cfg_ready_a, head_a, shift_en_a, isol_n_a, busy_a, done_a, error_a, shift_count_a}, 32'd0);
        @(negedge prog_clk);
        prog_reset = 1'b0;
        clear_stats();
        a_words = {8'hA5, 8'h3C, 8'hF0};
        run_a("rerun");
        check("rerun_probe_shifts", 32'(a_probe_sh), 32'd20);
        check("rerun_contents", 32'(chain_a[19:0]), 32'hA53CF);
        check("rerun_done_isol", {30'd0, isol_n_a, error_a} | (32'(a_done) << 2), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Upstream driver of the configuration-flip-flop (ccff) chain that feeds ccff_head of the first I/O grid tile and observes ccff_tail of the last tile.
- Accepts bitstream words over a valid/ready interface and serialises them MSB-first onto the chain.
- Gates chain shifting through a shift-enable output.
- Before loading, runs a marker probe that checks chain length/continuity.
- Holds isol_n low (I/O isolated) until a load completes successfully.

Parameters:
- CHAIN_LEN, 64, number of ccff bits in the chain (>=2).
- WORD_W, 8, bitstream word width (>=1).
- PROBE_EN, 1, 1 = run the length probe before load; 0 = skip the probe.
- CNT_W, $clog2(2*CHAIN_LEN+1), width of the shift counter.

Ports:
- prog_clk  in  1  configuration clock; the only clock.
- prog_reset  in  1  asynchronous active-high reset.
- start  in  1  single-cycle request to begin probe+load.
- cfg_data  in  WORD_W  bitstream word; bit [WORD_W-1] is shifted first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  word accepted when cfg_valid&cfg_ready.
- ccff_head  out  1  serial data to the chain.
- ccff_shift_en  out  1  chain shifts on the prog_clk edge ending a cycle in which this is high (drives the external clock gate).
- ccff_tail  in  1  serial output of the last chain stage.
- isol_n  out  1  0 = pads isolated.
- busy  out  1  FSM not in IDLE/DONE/ERR.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky probe failure; cleared by the next start or by reset.
- shift_count  out  CNT_W  shifts performed in the current phase.

Behaviour:
- Reset values (async on prog_reset): FSM=IDLE, all outputs 0 (isol_n=0, cfg_ready=0, ccff_head=0, ccff_shift_en=0), word buffer empty, counters 0.
- States: IDLE, PROBE, LOAD, DONE, ERR.
- IDLE/DONE/ERR + start:
  - go to PROBE if PROBE_EN, else LOAD;
  - clear error and shift_count;
  - isol_n=0.
  - start while busy is ignored.
- PROBE, cycle 0: shift_en=1, head=1 (marker).
- PROBE, later cycles: shift_en=1, head=0. shift_count increments on each shifted edge.
- PROBE check, combinational sample of ccff_tail each cycle:
  - tail=1 with shift_count<CHAIN_LEN -> ERR (chain short);
  - tail=1 with shift_count==CHAIN_LEN -> no shift that cycle; go to LOAD; shift_count=0;
  - shift_count reaches 2*CHAIN_LEN with no tail -> ERR (chain open/long).
- LOAD:
  - one-word holding buffer; cfg_ready = buffer empty OR last valid bit of the buffer shifts this cycle (zero-bubble refill).
  - Each cycle with a buffered bit: shift_en=1, head = current bit; bit pointer decrements.
  - Buffer empty: shift_en=0, head=0 (stall; the chain holds).
  - Total words consumed = ceil(CHAIN_LEN/WORD_W). In the final word only the top CHAIN_LEN mod WORD_W bits are shifted (all bits if 0); the rest are discarded.
  - cfg_ready=0 once the final word has been accepted.
  - After exactly CHAIN_LEN shifts -> DONE. The probe marker has left the chain by then.
- DONE: done=1 for the entry cycle only; isol_n=1 from the entry cycle and held; shift_en=0.
- ERR: error=1; isol_n stays 0; shift_en=0; cfg_ready=0.
- prog_reset asserted mid-operation: immediate return to reset values; the partial chain contents are left as-is, and a new start is needed.
- cfg_valid is ignored outside LOAD. No word is dropped: a handshake in the cycle LOAD is entered is honoured.

Decomposition:
- Shared package ccff_pkg:
  - FSM state enum (IDLE, PROBE, LOAD, DONE, ERR);
  - a function computing the word count ceil(CHAIN_LEN/WORD_W) and last-word bit count.
- One natural sub-module: ccff_word_serializer. It holds the buffer, bit pointer and valid/ready, and provides bit/bit_valid/last outputs.
- The top level holds the FSM, counters and probe check.

Test Plan:
- CHAIN_LEN=20, WORD_W=8, behavioural 20-stage shift-register model, words 0xA5,0x3C,0xF0 always valid, start pulse:
  - probe: tail=1 exactly at shift_count=20;
  - LOAD takes 20 shifted cycles; model holds 1010_0101_0011_1100_1111 (first bit at the far end);
  - done pulses once; isol_n=1.
- Same configuration, model of length 19: tail rises at shift_count=19 -> error=1, isol_n=0, no cfg_ready ever asserted.
- Broken chain (tail tied 0): error asserts after exactly 40 probe shifts; shift_en=0 afterwards.
- Stall: cfg_valid dropped for 5 cycles after the first word -> shift_en=0 and the model holds for those 5 cycles; final contents still correct; total LOAD cycles = 25.
- PROBE_EN=0, CHAIN_LEN=16, WORD_W=8, words 0xFF,0x00: LOAD is entered the cycle after start; exactly 2 handshakes; done after 16 shifts.
- Reset mid-LOAD after 7 shifts: all outputs return to 0 asynchronously. A following start re-runs the probe; the second load completes with correct contents.
